// File: rtl/int_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM states,
// and the lowest-index priority helper.
package int_pkg;

  localparam int N_SRC_DEFAULT = 6;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_CAUSE   = 2'd2;
  localparam logic [1:0] REG_EOI     = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Lowest set bit wins, so scanning from the top lets lower indices overwrite.
  function automatic logic [4:0] lowest_index(input logic [31:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/int_sync_edge.sv
// Two-flop synchronizer for one raw interrupt source, plus a registered
// rising-edge pulse and a matching-latency delayed level.
module int_sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic src_i,
  output logic level_o,
  output logic rise_o
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic rise_q, rise_d;

  always_comb begin
    s1_d   = src_i;
    s2_d   = s1_q;
    s3_d   = s2_q;
    rise_d = s2_q & ~s3_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      rise_q <= rise_d;
    end
  end

  assign level_o = s3_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller with a Wishbone register slave: pending/mask/cause/EOI
// registers and a two-state IDLE/ACTIVE service FSM.
module int_ctrl
  import int_pkg::*;
#(
  parameter int                N_SRC     = N_SRC_DEFAULT,
  parameter logic [N_SRC-1:0] EDGE_MASK = {N_SRC{1'b1}}
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             STB,
  input  logic             WE,
  input  logic [31:0]      ADDR,
  input  logic [31:0]      DAT_I,
  output logic [31:0]      DAT_O,
  output logic             ACK,
  input  logic [N_SRC-1:0] src,
  output logic             INT,
  output logic [31:0]      CAUSE
);

  logic [N_SRC-1:0] sync_level;
  logic [N_SRC-1:0] sync_rise;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    int_sync_edge u_sync (
      .clk    (clk),
      .rstn   (rstn),
      .src_i  (src[g]),
      .level_o(sync_level[g]),
      .rise_o (sync_rise[g])
    );
  end

  state_e           state_q, state_d;
  logic [4:0]       cause_q, cause_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic             reedge_q, reedge_d;
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;

  logic             bus_go, wr_pend, wr_mask, eoi, cause_rise;
  logic [1:0]       reg_sel;
  logic [N_SRC-1:0] clr_vec, hot_vec;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign unused_bits = ^{ADDR[31:4], ADDR[1:0], DAT_I};

  always_comb begin
    reg_sel = ADDR[3:2];
    bus_go  = STB & ~ack_q;
    wr_pend = bus_go & WE & (reg_sel == REG_PENDING);
    wr_mask = bus_go & WE & (reg_sel == REG_MASK);
    eoi     = bus_go & WE & (reg_sel == REG_EOI) & (state_q == ST_ACTIVE);
    hot_vec = pending_q & mask_q;
  end

  always_comb begin
    cause_rise = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (cause_q == 5'(i) && sync_rise[i]) cause_rise = 1'b1;
    end
  end

  // A fresh edge on the in-service source must survive its own EOI.
  always_comb begin
    reedge_d = reedge_q;
    if (state_q == ST_IDLE || eoi) reedge_d = 1'b0;
    else if (cause_rise)           reedge_d = 1'b1;
  end

  // Edge bits: W1C and EOI clear, a same-cycle edge wins. Level bits track the source.
  always_comb begin
    clr_vec = '0;
    if (wr_pend) clr_vec = DAT_I[N_SRC-1:0];
    for (int i = 0; i < N_SRC; i++) begin
      if (eoi && !reedge_q && cause_q == 5'(i)) clr_vec[i] = 1'b1;
    end
    clr_vec   = clr_vec & EDGE_MASK;
    pending_d = (((pending_q & ~clr_vec) | sync_rise) & EDGE_MASK)
              | (sync_level & ~EDGE_MASK);
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (hot_vec != '0) begin
          cause_d = lowest_index(32'(hot_vec));
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (eoi) begin
          cause_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mask_d = wr_mask ? DAT_I[N_SRC-1:0] : mask_q;
    ack_d  = bus_go;
    case (reg_sel)
      REG_PENDING: rdata = 32'(pending_q);
      REG_MASK:    rdata = 32'(mask_q);
      REG_CAUSE:   rdata = {state_q == ST_ACTIVE, 26'b0, cause_q};
      default:     rdata = 32'b0;
    endcase
    dat_d = (bus_go & ~WE) ? rdata : 32'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cause_q   <= '0;
      mask_q    <= '0;
      pending_q <= '0;
      reedge_q  <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
      reedge_q  <= reedge_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
    end
  end

  assign INT   = (state_q == ST_ACTIVE);
  assign CAUSE = {27'b0, cause_q};
  assign ACK   = ack_q;
  assign DAT_O = dat_q;

endmodule
